// File: rtl/sal_pkt_fifo_pkg.sv
// Shared types and constants for the packet-mode RX FIFO.
// Holds the write-FSM state enum and the bit positions of the debug_o status word.
package sal_pkt_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PKT,
        DISCARD
    } wr_state_t;

    localparam int unsigned DBG_OVF       = 31;
    localparam int unsigned DBG_PROTO     = 30;
    localparam int unsigned DBG_FULL      = 29;
    localparam int unsigned DBG_WPTR_MSB  = 28;
    localparam int unsigned DBG_WPTR_LSB  = 16;
    localparam int unsigned DBG_RVALID    = 15;
    localparam int unsigned DBG_RDPTR_MSB = 12;
    localparam int unsigned DBG_PTR_W     = 13;

endpackage

// File: rtl/sal_pkt_fifo_wctl.sv
// Write-side controller of the packet FIFO.
// Runs the IDLE/PKT/DISCARD framing FSM and owns the tentative and committed
// write pointers, handling commit, rollback, protocol errors and overflow discard.
// Inputs : clk, rst_n, wvalid/wsop/weop/wdrop beat attributes, rdptr from the reader.
// Outputs: wready, afull, full, wr_en/wr_addr for the storage array, commit pulse,
//          both write pointers and the ovf_drop/proto_err sticky flags.
module sal_pkt_fifo_wctl
    import sal_pkt_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LG2   = 4,
    parameter int unsigned AFULL_THRES = (2**DEPTH_LG2) - 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wvalid,
    input  logic                 wsop,
    input  logic                 weop,
    input  logic                 wdrop,
    input  logic [DEPTH_LG2:0]   rdptr,
    output logic                 wready,
    output logic                 afull,
    output logic                 full,
    output logic                 wr_en,
    output logic [DEPTH_LG2-1:0] wr_addr,
    output logic                 commit,
    output logic [DEPTH_LG2:0]   wptr_tent,
    output logic [DEPTH_LG2:0]   wptr_cmt,
    output logic                 ovf_drop,
    output logic                 proto_err
);

    localparam logic [DEPTH_LG2:0] FULL_OCC = {1'b1, {DEPTH_LG2{1'b0}}};
    localparam logic [DEPTH_LG2:0] PTR_ONE  = {{DEPTH_LG2{1'b0}}, 1'b1};

    wr_state_t            state;
    logic [DEPTH_LG2:0]   occ;
    logic [DEPTH_LG2:0]   base;
    logic                 ovf;
    logic                 accept;
    logic                 restart;

    always_comb begin
        occ     = wptr_tent - rdptr;
        full    = (occ == FULL_OCC);
        // The open packet alone fills the array and can never be committed.
        ovf     = (state == PKT) && full && (wptr_cmt == rdptr);
        wready  = rst_n && (!full || (state == DISCARD) || ovf);
        afull   = !rst_n || (32'(occ) >= AFULL_THRES);
        accept  = wvalid && wready;
        // A sop inside an open packet restarts writing at the committed end.
        restart = (state == PKT) && wsop;
        base    = restart ? wptr_cmt : wptr_tent;
        wr_en   = accept && !ovf && ((state == PKT) || ((state == IDLE) && wsop));
        wr_addr = base[DEPTH_LG2-1:0];
        commit  = wr_en && weop && !wdrop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wptr_tent <= '0;
            wptr_cmt  <= '0;
            ovf_drop  <= 1'b0;
            proto_err <= 1'b0;
        end else if (accept) begin
            if (state == DISCARD) begin
                if (weop) state <= IDLE;
            end else if (ovf) begin
                wptr_tent <= wptr_cmt;
                ovf_drop  <= 1'b1;
                state     <= weop ? IDLE : DISCARD;
            end else if (!wr_en) begin
                proto_err <= 1'b1;
            end else begin
                if (restart) proto_err <= 1'b1;
                if (weop) begin
                    state <= IDLE;
                    if (wdrop) begin
                        wptr_tent <= wptr_cmt;
                    end else begin
                        wptr_tent <= base + PTR_ONE;
                        wptr_cmt  <= base + PTR_ONE;
                    end
                end else begin
                    wptr_tent <= base + PTR_ONE;
                    state     <= PKT;
                end
            end
        end
    end

endmodule

// File: rtl/sal_pkt_fifo.sv
// Packet-mode RX FIFO: beats become visible to the reader only once their
// packet's eop is committed; packets flagged bad at eop are rolled back.
// Ports: clk/rst_n (sync, active-low); write side wvalid_i/wready_o/wsop_i/
//        weop_i/wdrop_i/wdata_i/afull_o; read side rvalid_o/rready_i/rsop_o/
//        reop_o/rdata_o/aempty_o; pkt_cnt_o committed packet count; debug_o status.
// Build option: SAL_PKT_FIFO_OUT_REG_EN adds a 2-entry registered output stage.
module sal_pkt_fifo
    import sal_pkt_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LG2    = 4,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned PKT_CNT_W    = 8,
    parameter int unsigned AFULL_THRES  = (2**DEPTH_LG2) - 4,
    parameter int unsigned AEMPTY_THRES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic                  wsop_i,
    input  logic                  weop_i,
    input  logic                  wdrop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  afull_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  rsop_o,
    output logic                  reop_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  aempty_o,
    output logic [PKT_CNT_W-1:0]  pkt_cnt_o,
    output logic [31:0]           debug_o
);

    localparam logic [DEPTH_LG2:0] PTR_ONE = {{DEPTH_LG2{1'b0}}, 1'b1};
    localparam int unsigned CNT_CW = (DEPTH_LG2 + 1 > PKT_CNT_W) ? DEPTH_LG2 + 1 : PKT_CNT_W;
    localparam logic [CNT_CW-1:0] CNT_MAX = CNT_CW'({PKT_CNT_W{1'b1}});

    logic [DATA_WIDTH:0]   mem [0:(2**DEPTH_LG2)-1];
    logic                  wr_en;
    logic [DEPTH_LG2-1:0]  wr_addr;
    logic                  commit;
    logic                  full;
    logic                  ovf_drop;
    logic                  proto_err;
    logic [DEPTH_LG2:0]    wptr_tent;
    logic [DEPTH_LG2:0]    wptr_cmt;
    logic [DEPTH_LG2:0]    rdptr;
    logic [DEPTH_LG2:0]    pkt_cnt;
    logic [CNT_CW-1:0]     cnt_wide;
    logic                  sop_q;
    logic                  arr_valid;
    logic                  arr_pop;
    logic                  pkt_dec;
    logic                  head_eop;
    logic [DATA_WIDTH-1:0] head_data;
    logic [31:0]           cmt_occ;

    sal_pkt_fifo_wctl #(
        .DEPTH_LG2   (DEPTH_LG2),
        .AFULL_THRES (AFULL_THRES)
    ) u_wctl (
        .clk       (clk),
        .rst_n     (rst_n),
        .wvalid    (wvalid_i),
        .wsop      (wsop_i),
        .weop      (weop_i),
        .wdrop     (wdrop_i),
        .rdptr     (rdptr),
        .wready    (wready_o),
        .afull     (afull_o),
        .full      (full),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .commit    (commit),
        .wptr_tent (wptr_tent),
        .wptr_cmt  (wptr_cmt),
        .ovf_drop  (ovf_drop),
        .proto_err (proto_err)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {weop_i, wdata_i};
    end

    assign arr_valid = (rdptr != wptr_cmt);
    assign {head_eop, head_data} = mem[rdptr[DEPTH_LG2-1:0]];

`ifdef SAL_PKT_FIFO_OUT_REG_EN
    logic [DATA_WIDTH+1:0] skid_q [0:1];
    logic [1:0]            skid_v;
    logic [DATA_WIDTH+1:0] arr_beat;
    logic                  out_pop;

    // Fill only while the second slot is free; with rready_i held high the
    // head slot is replaced every cycle, keeping one beat per clock.
    assign arr_pop  = arr_valid && !skid_v[1];
    assign arr_beat = {sop_q, head_eop, head_data};
    assign out_pop  = skid_v[0] && rready_i;
    assign rvalid_o = skid_v[0];
    assign {rsop_o, reop_o, rdata_o} = skid_q[0];
    assign pkt_dec  = out_pop && reop_o;
    assign cmt_occ  = 32'(wptr_cmt - rdptr) + 32'(skid_v[0]) + 32'(skid_v[1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_v    <= '0;
            skid_q[0] <= {1'b1, 1'b0, {DATA_WIDTH{1'b0}}};
            skid_q[1] <= '0;
        end else begin
            case ({arr_pop, out_pop})
                2'b01: begin
                    skid_q[0] <= skid_q[1];
                    skid_v    <= {1'b0, skid_v[1]};
                end
                2'b10: begin
                    if (skid_v[0]) begin
                        skid_q[1] <= arr_beat;
                        skid_v[1] <= 1'b1;
                    end else begin
                        skid_q[0] <= arr_beat;
                        skid_v[0] <= 1'b1;
                    end
                end
                2'b11:   skid_q[0] <= arr_beat;
                default: ;
            endcase
        end
    end
`else
    assign arr_pop  = arr_valid && rready_i;
    assign rvalid_o = arr_valid;
    assign rsop_o   = sop_q;
    assign reop_o   = arr_valid && head_eop;
    assign rdata_o  = head_data;
    assign pkt_dec  = arr_pop && head_eop;
    assign cmt_occ  = 32'(wptr_cmt - rdptr);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdptr   <= '0;
            sop_q   <= 1'b1;
            pkt_cnt <= '0;
        end else begin
            if (arr_pop) begin
                rdptr <= rdptr + PTR_ONE;
                sop_q <= head_eop;
            end
            case ({commit, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
                default: ;
            endcase
        end
    end

    assign cnt_wide  = CNT_CW'(pkt_cnt);
    assign pkt_cnt_o = (cnt_wide > CNT_MAX) ? PKT_CNT_W'(CNT_MAX) : PKT_CNT_W'(cnt_wide);
    assign aempty_o  = (cmt_occ <= AEMPTY_THRES);

    always_comb begin
        debug_o                              = '0;
        debug_o[DBG_OVF]                     = ovf_drop;
        debug_o[DBG_PROTO]                   = proto_err;
        debug_o[DBG_FULL]                    = full;
        debug_o[DBG_WPTR_MSB:DBG_WPTR_LSB]   = DBG_PTR_W'(wptr_tent);
        debug_o[DBG_RVALID]                  = rvalid_o;
        debug_o[DBG_RDPTR_MSB:0]             = DBG_PTR_W'(rdptr);
    end

endmodule
